// File: rtl/load_store_unit_if.sv
// Memory bus between the load/store unit (master) and a word-wide memory port (slave).
//   busReq    : master holds high while a transfer is outstanding
//   busWe     : 1 = store, 0 = load
//   busAddr   : word-aligned byte address (bits [1:0] always 00)
//   busWData  : store data, already replicated onto the target lanes
//   busByteEn : byte lanes written (1111 for loads)
//   busReady  : slave completes the transfer on a cycle where busReq & busReady
//   busRData  : full read word, sampled when busReady is high
interface load_store_unit_if;
  logic        busReq;
  logic        busWe;
  logic [31:0] busAddr;
  logic [31:0] busWData;
  logic [3:0]  busByteEn;
  logic        busReady;
  logic [31:0] busRData;

  modport master (
    output busReq, busWe, busAddr, busWData, busByteEn,
    input  busReady, busRData
  );

  modport slave (
    input  busReq, busWe, busAddr, busWData, busByteEn,
    output busReady, busRData
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word accesses from the memory stage into single word-wide
// bus transfers, with alignment checks, load extension and a 16-cycle bus timeout.
// Ports:
//   iClk, iRst  : clock and synchronous active-high reset
//   iMemRead    : load request            iMemWrite  : store request (wins over load)
//   iFunct3     : access size / signedness
//   iAddr       : byte address            iWriteData : store data, LSB-aligned
//   oStall      : hold the pipeline       oLoadValid : oLoadData valid this cycle
//   oLoadData   : extended load result    oFault     : one-cycle misaligned/illegal/timeout pulse
//   bus         : memory bus, master side
module load_store_unit (
  input  logic                      iClk,
  input  logic                      iRst,
  input  logic                      iMemRead,
  input  logic                      iMemWrite,
  input  logic [2:0]                iFunct3,
  input  logic [31:0]               iAddr,
  input  logic [31:0]               iWriteData,
  output logic                      oStall,
  output logic                      oLoadValid,
  output logic [31:0]               oLoadData,
  output logic                      oFault,
  load_store_unit_if.master         bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e      state;
  logic [3:0]  timeoutCnt;
  logic        isLoadQ;
  logic [2:0]  funct3Q;
  logic [1:0]  laneQ;

  logic        request;
  logic        isStore;
  logic        funct3Ok;
  logic        alignOk;
  logic        accept;
  logic        illegal;
  logic [3:0]  storeBe;
  logic [31:0] storeData;

  // Picks the addressed byte/half out of the bus word and extends it.
  function automatic logic [31:0] extendLoad(input logic [2:0] f3, input logic [1:0] lane,
                                             input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  extendLoad = {{24{b[7]}}, b};
      3'b001:  extendLoad = {{16{h[15]}}, h};
      3'b100:  extendLoad = {24'h0, b};
      3'b101:  extendLoad = {16'h0, h};
      default: extendLoad = word;
    endcase
  endfunction

  always_comb begin
    request  = iMemRead | iMemWrite;
    isStore  = iMemWrite;
    funct3Ok = isStore ? (iFunct3 inside {3'b000, 3'b001, 3'b010})
                       : (iFunct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    alignOk  = 1'b1;
    if (iFunct3[1:0] == 2'b01) alignOk = ~iAddr[0];
    if (iFunct3[1:0] == 2'b10) alignOk = (iAddr[1:0] == 2'b00);
    accept   = (state == StIdle) & request & funct3Ok & alignOk;
    illegal  = (state == StIdle) & request & ~(funct3Ok & alignOk);

    storeBe   = 4'b1111;
    storeData = iWriteData;
    case (iFunct3[1:0])
      2'b00: begin
        storeBe   = 4'b0001 << iAddr[1:0];
        storeData = {4{iWriteData[7:0]}};
      end
      2'b01: begin
        storeBe   = 4'b0011 << {iAddr[1], 1'b0};
        storeData = {2{iWriteData[15:0]}};
      end
      default: ;
    endcase

    // Stall must rise in the accept cycle itself, before the state register changes.
    oStall = (state == StAccess) | accept;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state         <= StIdle;
      timeoutCnt    <= 4'd0;
      isLoadQ       <= 1'b0;
      funct3Q       <= 3'b000;
      laneQ         <= 2'b00;
      oLoadValid    <= 1'b0;
      oLoadData     <= 32'h0;
      oFault        <= 1'b0;
      bus.busReq    <= 1'b0;
      bus.busWe     <= 1'b0;
      bus.busAddr   <= 32'h0;
      bus.busWData  <= 32'h0;
      bus.busByteEn <= 4'b0000;
    end else begin
      oLoadValid <= 1'b0;
      oFault     <= 1'b0;
      unique case (state)
        StIdle: begin
          if (accept) begin
            state         <= StAccess;
            timeoutCnt    <= 4'd0;
            isLoadQ       <= ~isStore;
            funct3Q       <= iFunct3;
            laneQ         <= iAddr[1:0];
            bus.busReq    <= 1'b1;
            bus.busWe     <= isStore;
            bus.busAddr   <= {iAddr[31:2], 2'b00};
            bus.busWData  <= isStore ? storeData : 32'h0;
            bus.busByteEn <= isStore ? storeBe : 4'b1111;
          end else if (illegal) begin
            oFault <= 1'b1;
          end
        end
        StAccess: begin
          if (bus.busReady) begin
            state      <= StDone;
            bus.busReq <= 1'b0;
            if (isLoadQ) begin
              oLoadValid <= 1'b1;
              oLoadData  <= extendLoad(funct3Q, laneQ, bus.busRData);
            end
          end else if (timeoutCnt == 4'd15) begin
            // 16th consecutive cycle without ready: give up and report.
            state      <= StDone;
            bus.busReq <= 1'b0;
            oFault     <= 1'b1;
          end else begin
            timeoutCnt <= timeoutCnt + 4'd1;
          end
        end
        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        memRead;
  logic        memWrite;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] writeData;
  logic        stall;
  logic        loadValid;
  logic [31:0] loadData;
  logic        fault;

  int checks = 0;
  int errors = 0;

  load_store_unit_if bus ();

  load_store_unit dut (
    .iClk       (clk),
    .iRst       (rst),
    .iMemRead   (memRead),
    .iMemWrite  (memWrite),
    .iFunct3    (funct3),
    .iAddr      (addr),
    .iWriteData (writeData),
    .oStall     (stall),
    .oLoadValid (loadValid),
    .oLoadData  (loadData),
    .oFault     (fault),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        rd;
    bit        wr;
    bit [2:0]  f3;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [31:0] rdata;
    int        waitCyc;
    bit        expLegal;
    bit        expWe;
    bit [31:0] expAddr;
    bit [31:0] expWData;
    bit [3:0]  expBe;
    bit [31:0] expLoad;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: derived from access size and byte offset with plain arithmetic.
  task automatic model(input bit rd, input bit wr, input bit [2:0] f3, input bit [31:0] a,
                       input bit [31:0] wd, input bit [31:0] rdv,
                       output bit legal, output bit we, output bit [31:0] eAddr,
                       output bit [31:0] eWData, output bit [3:0] eBe, output bit [31:0] eLoad);
    int unsigned size;
    int unsigned off;
    longint unsigned mask;
    longint unsigned field;
    size = 1 << f3[1:0];
    off  = a % 4;
    we   = wr;
    if (wr) legal = (f3 <= 3'd2);
    else    legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
    if (size > 4 || (off % size) != 0) legal = 1'b0;
    eAddr  = a - off;
    eWData = 32'h0;
    eBe    = 4'hF;
    eLoad  = 32'h0;
    mask   = (64'd1 << (8 * size)) - 1;
    if (wr) begin
      eBe = 4'(((1 << size) - 1) << off);
      if (size == 1)      eWData = (wd & 32'hFF) * 32'h01010101;
      else if (size == 2) eWData = (wd & 32'hFFFF) * 32'h00010001;
      else                eWData = wd;
    end else if (rd) begin
      field = (64'(rdv) >> (8 * off)) & mask;
      if (f3[2] == 1'b0 && size < 4 && field >= ((mask + 1) / 2)) field = field | ~mask;
      eLoad = 32'(field);
    end
  endtask

  task automatic runAccess(input string tag, input bit rd, input bit wr, input bit [2:0] f3,
                           input bit [31:0] a, input bit [31:0] wd, input bit [31:0] rdv,
                           input int waitCyc, input bit expLegal, input bit expWe,
                           input bit [31:0] expAddr, input bit [31:0] expWData,
                           input bit [3:0] expBe, input bit [31:0] expLoad);
    bit timedOut;
    timedOut = (waitCyc >= 16);
    @(posedge clk); #1;
    memRead       = rd;
    memWrite      = wr;
    funct3        = f3;
    addr          = a;
    writeData     = wd;
    bus.busReady  = 1'b1;  // stray ready while idle must be ignored
    bus.busRData  = rdv;
    @(negedge clk);
    check({tag, " acceptStall"}, 32'(stall), 32'(expLegal));
    check({tag, " idleReq"}, 32'(bus.busReq), 32'd0);
    @(posedge clk); #1;
    memRead      = 1'b0;
    memWrite     = 1'b0;
    bus.busReady = 1'b0;
    if (!expLegal) begin
      @(negedge clk);
      check({tag, " faultPulse"}, 32'(fault), 32'd1);
      check({tag, " faultNoReq"}, 32'(bus.busReq), 32'd0);
      check({tag, " faultNoStall"}, 32'(stall), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check({tag, " faultOneCycle"}, 32'(fault), 32'd0);
      return;
    end
    for (int i = 0; i < 16; i++) begin
      bus.busReady = (i == waitCyc);
      @(negedge clk);
      check({tag, " accReq"}, 32'(bus.busReq), 32'd1);
      check({tag, " accStall"}, 32'(stall), 32'd1);
      if (i == 0 || i == waitCyc || i == 15) begin
        check({tag, " busAddr"}, bus.busAddr, expAddr);
        check({tag, " busBe"}, 32'(bus.busByteEn), 32'(expBe));
        check({tag, " busWe"}, 32'(bus.busWe), 32'(expWe));
        if (expWe) check({tag, " busWData"}, bus.busWData, expWData);
      end
      @(posedge clk); #1;
      bus.busReady = 1'b0;
      if (i == waitCyc) break;
    end
    @(negedge clk);
    check({tag, " doneStall"}, 32'(stall), 32'd0);
    check({tag, " doneReq"}, 32'(bus.busReq), 32'd0);
    check({tag, " doneValid"}, 32'(loadValid), 32'(!expWe && !timedOut));
    check({tag, " doneFault"}, 32'(fault), 32'(timedOut));
    if (!expWe && !timedOut) check({tag, " loadData"}, loadData, expLoad);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, " idleValid"}, 32'(loadValid), 32'd0);
    check({tag, " idleFault"}, 32'(fault), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit        lg, we;
    bit [31:0] ea, ew, el;
    bit [3:0]  eb;
    bit        rd, wr;
    bit [2:0]  f3;
    bit [31:0] a, wd, rdv;
    int        wc;

    vecs[0]  = '{1, 0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0,
                 1, 0, 32'h100, 32'h0,        4'b1111, 32'hDEADBEEF};
    vecs[1]  = '{1, 0, 3'b000, 32'h103, 32'h0,        32'h80FFFFFF, 2,
                 1, 0, 32'h100, 32'h0,        4'b1111, 32'hFFFFFF80};
    vecs[2]  = '{1, 0, 3'b100, 32'h103, 32'h0,        32'h80FFFFFF, 0,
                 1, 0, 32'h100, 32'h0,        4'b1111, 32'h00000080};
    vecs[3]  = '{1, 0, 3'b101, 32'h102, 32'h0,        32'hBEEF1234, 0,
                 1, 0, 32'h100, 32'h0,        4'b1111, 32'h0000BEEF};
    vecs[4]  = '{1, 0, 3'b001, 32'h102, 32'h0,        32'h80010000, 1,
                 1, 0, 32'h100, 32'h0,        4'b1111, 32'hFFFF8001};
    vecs[5]  = '{0, 1, 3'b000, 32'h201, 32'h000000A5, 32'h0,        0,
                 1, 1, 32'h200, 32'hA5A5A5A5, 4'b0010, 32'h0};
    vecs[6]  = '{0, 1, 3'b001, 32'h202, 32'h00001234, 32'h0,        1,
                 1, 1, 32'h200, 32'h12341234, 4'b1100, 32'h0};
    vecs[7]  = '{1, 1, 3'b010, 32'h300, 32'h11223344, 32'hFFFFFFFF, 0,
                 1, 1, 32'h300, 32'h11223344, 4'b1111, 32'h0};
    vecs[8]  = '{1, 0, 3'b010, 32'h102, 32'h0,        32'h0,        0,
                 0, 0, 32'h0,   32'h0,        4'b0000, 32'h0};
    vecs[9]  = '{0, 1, 3'b001, 32'h203, 32'h0,        32'h0,        0,
                 0, 1, 32'h0,   32'h0,        4'b0000, 32'h0};
    vecs[10] = '{1, 0, 3'b011, 32'h100, 32'h0,        32'h0,        0,
                 0, 0, 32'h0,   32'h0,        4'b0000, 32'h0};
    vecs[11] = '{0, 1, 3'b100, 32'h100, 32'h0,        32'h0,        0,
                 0, 1, 32'h0,   32'h0,        4'b0000, 32'h0};
    vecs[12] = '{1, 0, 3'b100, 32'h101, 32'h0,        32'h0000AB00, 0,
                 1, 0, 32'h100, 32'h0,        4'b1111, 32'h000000AB};
    vecs[13] = '{0, 1, 3'b000, 32'h203, 32'hFFFFFF7E, 32'h0,        3,
                 1, 1, 32'h200, 32'h7E7E7E7E, 4'b1000, 32'h0};

    rst          = 1'b1;
    memRead      = 1'b0;
    memWrite     = 1'b0;
    funct3       = 3'b000;
    addr         = 32'h0;
    writeData    = 32'h0;
    bus.busReady = 1'b0;
    bus.busRData = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst stall", 32'(stall), 32'd0);
    check("rst valid", 32'(loadValid), 32'd0);
    check("rst fault", 32'(fault), 32'd0);
    check("rst req", 32'(bus.busReq), 32'd0);
    check("rst be", 32'(bus.busByteEn), 32'd0);
    check("rst addr", bus.busAddr, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      runAccess($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr,
                vecs[i].wdata, vecs[i].rdata, vecs[i].waitCyc, vecs[i].expLegal,
                vecs[i].expWe, vecs[i].expAddr, vecs[i].expWData, vecs[i].expBe,
                vecs[i].expLoad);
    end

    // Bus never ready: 16 access cycles, then timeout fault with no load valid.
    runAccess("timeout", 1, 0, 3'b010, 32'h400, 32'h0, 32'h12345678, 99,
              1, 0, 32'h400, 32'h0, 4'b1111, 32'h0);

    // Reset in the third access cycle abandons the transfer.
    @(posedge clk); #1;
    memRead = 1'b1;
    funct3  = 3'b010;
    addr    = 32'h500;
    @(posedge clk); #1;
    memRead = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("midRst reqBefore", 32'(bus.busReq), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midRst req", 32'(bus.busReq), 32'd0);
    check("midRst stall", 32'(stall), 32'd0);
    check("midRst valid", 32'(loadValid), 32'd0);
    check("midRst fault", 32'(fault), 32'd0);
    check("midRst we", 32'(bus.busWe), 32'd0);
    check("midRst be", 32'(bus.busByteEn), 32'd0);
    check("midRst addr", bus.busAddr, 32'd0);
    check("midRst wdata", bus.busWData, 32'd0);
    check("midRst data", loadData, 32'd0);
    rst = 1'b0;
    runAccess("afterRst", 1, 0, 3'b010, 32'h100, 32'h0, 32'hCAFEF00D, 0,
              1, 0, 32'h100, 32'h0, 4'b1111, 32'hCAFEF00D);

    // Randomized accesses against the reference model.
    for (int n = 0; n < 40; n++) begin
      wr  = $urandom_range(0, 1);
      rd  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      f3  = 3'($urandom_range(0, 7));
      a   = 32'h1000 + 32'($urandom_range(0, 255));
      wd  = $urandom;
      rdv = $urandom;
      wc  = ($urandom_range(0, 9) == 0) ? 17 : int'($urandom_range(0, 3));
      model(rd, wr, f3, a, wd, rdv, lg, we, ea, ew, eb, el);
      runAccess($sformatf("rand%0d", n), rd, wr, f3, a, wd, rdv, wc, lg, we, ea, ew, eb, el);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
